// File: rtl/if_fetch_unit.sv
// IF-stage PC and fetch controller.
// Keeps at most one instruction read outstanding to the IM wrapper and delivers
// {pc, inst} into the IF/ID register. A taken branch resolved in ID redirects the
// PC and squashes any wrong-path fetch still in flight. A one-entry skid buffer
// catches a response that lands while ID is stalled on a full IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcsrc,
  input  logic [31:0] target_pc,
  input  logic        id_stall,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP_REQ,
    S_DROP_WAIT
  } state_t;

  // One fetched instruction with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  state_t      state, state_nxt;
  logic [31:0] pc;          // next PC to request on the correct path
  logic [31:0] req_pc;      // PC of the request currently outstanding
  logic [31:0] drop_addr;   // address of a wrong-path request still being offered
  logic [31:0] ifid_inst_q;
  logic        skid_valid;
  fetch_ent_t  skid;

  logic        redir;
  logic        consume;
  logic        req_hs;
  logic        rsp_take;
  logic [31:0] target_word;

  // The low target bits are architecturally dropped; fold them into a sink.
  logic        unused_target_lo;
  assign unused_target_lo = ^target_pc[1:0];

  // A stalled ID stage will re-assert its branch, so only act when it moves.
  assign redir       = pcsrc && !id_stall;
  assign consume     = ifid_valid && !id_stall;
  assign req_hs      = im_req_valid && im_req_ready;
  assign target_word = {target_pc[31:2], 2'b00};
  // A response is only kept when it belongs to the correct path and no redirect wins.
  assign rsp_take    = (state == S_WAIT) && im_rsp_valid && !redir;

  // Request channel: never offer a new fetch while the skid entry is occupied.
  always_comb begin
    im_req_valid = 1'b0;
    im_req_addr  = pc;
    case (state)
      S_REQ:      im_req_valid = !skid_valid;
      S_DROP_REQ: begin
        im_req_valid = 1'b1;
        im_req_addr  = drop_addr;
      end
      default:    im_req_valid = 1'b0;
    endcase
  end

  // Next-state logic; a redirect diverts in-flight requests into the drop states.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (redir) begin
          if (req_hs)            state_nxt = S_DROP_WAIT;
          else if (im_req_valid) state_nxt = S_DROP_REQ;
          else                   state_nxt = S_REQ;
        end else if (req_hs) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir)             state_nxt = im_rsp_valid ? S_REQ : S_DROP_WAIT;
        else if (im_rsp_valid) state_nxt = S_REQ;
      end
      S_DROP_REQ:  if (im_req_ready) state_nxt = S_DROP_WAIT;
      S_DROP_WAIT: if (im_rsp_valid) state_nxt = S_REQ;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // PC tracking: redirect wins over sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      if (redir)
        pc <= target_word;
      else if (state == S_REQ && req_hs)
        pc <= pc + 32'd4;
      if (state == S_REQ && req_hs)
        req_pc <= pc;
      // Remember the wrong-path address so it stays stable until accepted.
      if (state == S_REQ && redir && im_req_valid && !im_req_ready)
        drop_addr <= pc;
    end
  end

  // IF/ID register and skid buffer; redirect flushes both ahead of any load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid  <= 1'b0;
      ifid_pc     <= '0;
      ifid_inst_q <= NOP_INST;
      skid_valid  <= 1'b0;
      skid        <= '0;
    end else if (redir) begin
      ifid_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (rsp_take) begin
      if (!ifid_valid || consume) begin
        ifid_valid  <= 1'b1;
        ifid_pc     <= req_pc;
        ifid_inst_q <= im_rsp_data;
      end else begin
        skid_valid <= 1'b1;
        skid       <= '{pc: req_pc, inst: im_rsp_data};
      end
    end else if (consume) begin
      if (skid_valid) begin
        ifid_valid  <= 1'b1;
        ifid_pc     <= skid.pc;
        ifid_inst_q <= skid.inst;
        skid_valid  <= 1'b0;
      end else begin
        ifid_valid <= 1'b0;
      end
    end
  end

  // ID sees a harmless NOP whenever the IF/ID slot is empty.
  assign ifid_inst = ifid_valid ? ifid_inst_q : NOP_INST;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit. The reference model treats the IF/ID output
// as a program-order stream: consecutive words from RESET_PC, restarting at the
// word-aligned target on every accepted redirect and at RESET_PC on reset.
module tb_if_fetch_unit;

  localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] target_pc = '0;
  logic        id_stall = 1'b0;
  logic        im_req_valid;
  logic        im_req_ready = 1'b0;
  logic [31:0] im_req_addr;
  logic        im_rsp_valid = 1'b0;
  logic [31:0] im_rsp_data = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;

  // Second instance exercising the PC wrap at the top of the address space.
  logic        w_pcsrc = 1'b0;
  logic [31:0] w_target = '0;
  logic        w_stall = 1'b0;
  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_ifid_valid;
  logic [31:0] w_ifid_pc;
  logic [31:0] w_ifid_inst;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(MAIN_RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .target_pc(target_pc), .id_stall(id_stall),
    .im_req_valid(im_req_valid), .im_req_ready(im_req_ready), .im_req_addr(im_req_addr),
    .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_inst(ifid_inst)
  );

  if_fetch_unit #(.RESET_PC(WRAP_RESET_PC), .NOP_INST(NOP)) u_wrap (
    .clk(clk), .rst(rst), .pcsrc(w_pcsrc), .target_pc(w_target), .id_stall(w_stall),
    .im_req_valid(w_req_valid), .im_req_ready(w_req_ready), .im_req_addr(w_req_addr),
    .im_rsp_valid(w_rsp_valid), .im_rsp_data(w_rsp_data),
    .ifid_valid(w_ifid_valid), .ifid_pc(w_ifid_pc), .ifid_inst(w_ifid_inst)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int delivered = 0;

  // Stimulus knobs (percentages) and responder state, owned by the main process.
  int p_stall = 0, p_pcsrc = 0, p_ready = 100, fixed_lat = 1;
  logic        pending = 1'b0;
  logic [31:0] pend_addr = '0;
  int          cnt = 0;
  logic [31:0] hs_log[$];
  logic [31:0] w_log[$];
  logic [63:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: sample handshakes before the edge, drive after it.
  task automatic cycle();
    logic        hs;
    logic [31:0] ha;
    @(negedge clk);
    hs = im_req_valid && im_req_ready && !rst;
    ha = im_req_addr;
    if (hs) begin
      check("single_outstanding", 32'(pending || im_rsp_valid), 32'd0);
      hs_log.push_back(ha);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pending      = 1'b0;
      im_rsp_valid = 1'b0;
    end else begin
      if (hs) begin
        pending   = 1'b1;
        pend_addr = ha;
        cnt       = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      if (pending && cnt == 0) begin
        im_rsp_valid = 1'b1;
        im_rsp_data  = mem_word(pend_addr);
        pending      = 1'b0;
      end else begin
        im_rsp_valid = 1'b0;
        im_rsp_data  = $urandom;
        if (pending) cnt--;
      end
    end
    id_stall     = ($urandom % 100) < p_stall;
    pcsrc        = ($urandom % 100) < p_pcsrc;
    target_pc    = $urandom_range(0, 32'h3FF);
    im_req_ready = ($urandom % 100) < p_ready;
  endtask

  // Reference model: expected program-order stream, refilled each clock.
  initial begin
    logic [31:0] npc;
    npc = MAIN_RESET_PC;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        npc = MAIN_RESET_PC;
      end else if (pcsrc && !id_stall) begin
        exp_q.delete();
        npc = target_pc & ~32'h3;
      end
      while (exp_q.size() < 2) begin
        exp_q.push_back({npc, mem_word(npc)});
        npc += 32'd4;
      end
    end
  end

  // Monitor: pops the scoreboard on every IF/ID consume and checks the request channel.
  initial begin
    logic        pv, pr;
    logic [31:0] pa;
    logic [63:0] e;
    pv = 1'b0; pr = 1'b0; pa = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv && !pr) begin
          check("req_hold_valid", 32'(im_req_valid), 32'd1);
          check("req_hold_addr", im_req_addr, pa);
        end
        if (im_req_valid) check("req_align", 32'(im_req_addr[1:0]), 32'd0);
        if (ifid_valid && !id_stall) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_empty actual pc=%h expected=none", ifid_pc);
          end else begin
            e = exp_q.pop_front();
            check("ifid_pc", ifid_pc, e[63:32]);
            check("ifid_inst", ifid_inst, e[31:0]);
            delivered++;
          end
        end
        if (!ifid_valid) check("nop_when_invalid", ifid_inst, NOP);
      end
      pv = im_req_valid && !rst;
      pr = im_req_ready;
      pa = im_req_addr;
    end
  end

  // Wrap instance: always ready, response one cycle after accept.
  initial begin
    logic        h2;
    logic [31:0] a2;
    logic        seen_first;
    seen_first = 1'b0;
    forever begin
      @(negedge clk);
      h2 = w_req_valid && !rst;
      a2 = w_req_addr;
      if (h2 && w_log.size() < 2) w_log.push_back(a2);
      if (!rst && w_ifid_valid && !seen_first) begin
        check("wrap_first_pc", w_ifid_pc, WRAP_RESET_PC);
        check("wrap_first_inst", w_ifid_inst, mem_word(WRAP_RESET_PC));
        seen_first = 1'b1;
      end
      @(posedge clk);
      #1;
      w_rsp_valid = h2 && !rst;
      w_rsp_data  = mem_word(a2);
    end
  end

  initial begin
    int   d0;
    logic found;
    #2 rst = 1'b1;
    #2;
    check("rst_ifid_valid", 32'(ifid_valid), 32'd0);
    check("rst_ifid_pc", ifid_pc, 32'd0);
    check("rst_ifid_inst", ifid_inst, NOP);
    check("rst_req_valid", 32'(im_req_valid), 32'd0);
    check("rst_req_addr", im_req_addr, MAIN_RESET_PC);
    repeat (2) cycle();
    rst = 1'b0;
    hs_log.delete();
    check("idle_req_valid", 32'(im_req_valid), 32'd0);
    cycle();
    check("first_req_valid", 32'(im_req_valid), 32'd1);
    check("first_req_addr", im_req_addr, MAIN_RESET_PC);

    // Straight-line fetch, always ready, response two cycles after accept.
    d0 = delivered;
    repeat (40) cycle();
    if (hs_log.size() >= 3) begin
      check("seq_addr0", hs_log[0], 32'h0);
      check("seq_addr1", hs_log[1], 32'h4);
      check("seq_addr2", hs_log[2], 32'h8);
    end else begin
      check("seq_req_count", hs_log.size(), 3);
    end
    check("seq_progress", 32'(delivered - d0 >= 5), 32'd1);

    // Heavy ID stalls exercise the skid buffer.
    p_stall = 60; p_ready = 80; fixed_lat = -1;
    repeat (200) cycle();

    // Redirects mixed with stalls and back-pressure.
    p_stall = 25; p_pcsrc = 10; p_ready = 60;
    repeat (300) cycle();

    // Reset while a response is still owed.
    p_stall = 0; p_pcsrc = 0; p_ready = 100; fixed_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      if (pending && cnt > 0) found = 1'b1;
    end
    check("reset_window_found", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ifid_valid", 32'(ifid_valid), 32'd0);
    check("mid_rst_ifid_pc", ifid_pc, 32'd0);
    check("mid_rst_ifid_inst", ifid_inst, NOP);
    check("mid_rst_req_valid", 32'(im_req_valid), 32'd0);
    check("mid_rst_req_addr", im_req_addr, MAIN_RESET_PC);
    repeat (3) cycle();
    rst = 1'b0;
    hs_log.delete();
    repeat (20) cycle();
    if (hs_log.size() >= 1) check("refetch_addr", hs_log[0], MAIN_RESET_PC);
    else check("refetch_req_count", hs_log.size(), 1);

    // Everything random, then drain.
    p_stall = 30; p_pcsrc = 8; p_ready = 70; fixed_lat = -1;
    repeat (300) cycle();
    p_stall = 0; p_pcsrc = 0; p_ready = 100;
    repeat (40) cycle();
    check("total_progress", 32'(delivered >= 60), 32'd1);

    if (w_log.size() >= 2) begin
      check("wrap_addr0", w_log[0], WRAP_RESET_PC);
      check("wrap_addr1", w_log[1], 32'h0);
    end else begin
      check("wrap_req_count", w_log.size(), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
